// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scanner.
// The buffer depth constant is only used when KEYPAD_FIFO_EN is defined.
package keypad_pkg;

    localparam int KP_ROWS       = 4;
    localparam int KP_COLS       = 4;
    localparam int KP_CODE_W     = 4;
    localparam int KP_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        EMIT,
        WAIT_RELEASE
    } kp_state_e;

    // Index of the lowest active-low column; only meaningful when some column is low.
    function automatic logic [1:0] lowest_low(input logic [KP_COLS-1:0] cols);
        logic [1:0] idx;
        if (!cols[0])      idx = 2'd0;
        else if (!cols[1]) idx = 2'd1;
        else if (!cols[2]) idx = 2'd2;
        else               idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// keypad_tick_gen: free-running divider producing a one-cycle scan tick
// every TICK_DIV system clocks (clock enable, not a derived clock).
module keypad_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;

    // Count 0..TICK_DIV-1 and wrap.
    always_ff @(posedge clk) begin
        if (rst)                cnt_q <= '0;
        else if (cnt_q == LAST) cnt_q <= '0;
        else                    cnt_q <= cnt_q + CW'(1);
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix, debounces, and hands one
// code per press to the consumer over valid/ready.
// Macro KEYPAD_FIFO_EN: when defined the output buffer is a 4-entry
// first-word-fall-through FIFO; otherwise a single holding register.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int TICK_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [KP_ROWS-1:0]   row_out,
    input  logic [KP_COLS-1:0]   col_in,
    output logic                 key_valid,
    output logic [KP_CODE_W-1:0] key_code,
    input  logic                 key_ready,
    output logic                 overflow
);

    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_TICKS - 1);

    logic                 tick;
    logic [KP_COLS-1:0]   col_meta_q, col_sync_q;
    kp_state_e            state_q, state_d;
    logic [1:0]           row_q, row_d;
    logic [1:0]           col_q, col_d;
    logic [DW-1:0]        cnt_q, cnt_d;
    logic [KP_ROWS-1:0]   row_out_q;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 do_push;
    logic                 overflow_q;
    logic [KP_CODE_W-1:0] push_code;

    keypad_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Two-flop synchronizer for the asynchronous column inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_meta_q <= '1;
            col_sync_q <= '1;
        end else begin
            col_meta_q <= col_in;
            col_sync_q <= col_meta_q;
        end
    end

    // Scan FSM state, current row, latched column, shared debounce/release counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SCAN;
            row_q     <= 2'd0;
            col_q     <= 2'd0;
            cnt_q     <= '0;
            row_out_q <= 4'b1110;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            cnt_q     <= cnt_d;
            row_out_q <= ~(4'b0001 << row_d);
        end
    end

    // Next-state logic: everything except EMIT waits for a tick.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        case (state_q)
            SCAN: begin
                if (tick) begin
                    if (col_sync_q != 4'hF) begin
                        col_d   = lowest_low(col_sync_q);
                        cnt_d   = '0;
                        state_d = (DEBOUNCE_TICKS == 1) ? EMIT : DEBOUNCE;
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end
            end
            DEBOUNCE: begin
                if (tick) begin
                    if (!col_sync_q[col_q]) begin
                        cnt_d = cnt_q + DW'(1);
                        if (cnt_d == DB_LAST) state_d = EMIT;
                    end else begin
                        row_d   = row_q + 2'd1;
                        state_d = SCAN;
                    end
                end
            end
            EMIT: begin
                push    = 1'b1;
                cnt_d   = '0;
                state_d = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                // Row stays driven; need DEBOUNCE_TICKS all-high samples in a row.
                if (tick) begin
                    if (col_sync_q == 4'hF) begin
                        if (cnt_q == DB_LAST) begin
                            cnt_d   = '0;
                            row_d   = row_q + 2'd1;
                            state_d = SCAN;
                        end else begin
                            cnt_d = cnt_q + DW'(1);
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
            end
            default: state_d = SCAN;
        endcase
    end

    assign push_code = {row_q, col_q};
    assign do_push   = push && (!full || pop);

`ifdef KEYPAD_FIFO_EN
    logic [KP_CODE_W-1:0] fifo_mem_q [KP_FIFO_DEPTH];
    logic [1:0]           wr_ptr_q, rd_ptr_q;
    logic [2:0]           fill_q;

    assign full = (fill_q == 3'(KP_FIFO_DEPTH));
    assign pop  = (fill_q != 3'd0) && key_ready;

    // FWFT FIFO: pointers wrap naturally at 2 bits; a pop frees room for a same-edge push.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            fill_q   <= 3'd0;
            for (int i = 0; i < KP_FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
        end else begin
            if (do_push) begin
                fifo_mem_q[wr_ptr_q] <= push_code;
                wr_ptr_q             <= wr_ptr_q + 2'd1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
            fill_q <= fill_q + {2'b00, do_push} - {2'b00, pop};
        end
    end

    assign key_valid = (fill_q != 3'd0);
    assign key_code  = fifo_mem_q[rd_ptr_q];
`else
    logic                 hold_valid_q;
    logic [KP_CODE_W-1:0] hold_code_q;

    assign full = hold_valid_q;
    assign pop  = hold_valid_q && key_ready;

    // Single holding register; code stays put while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q <= 1'b0;
            hold_code_q  <= '0;
        end else if (do_push) begin
            hold_valid_q <= 1'b1;
            hold_code_q  <= push_code;
        end else if (pop) begin
            hold_valid_q <= 1'b0;
        end
    end

    assign key_valid = hold_valid_q;
    assign key_code  = hold_code_q;
`endif

    // Dropped push flags overflow for exactly the cycle after EMIT.
    always_ff @(posedge clk) begin
        if (rst) overflow_q <= 1'b0;
        else     overflow_q <= push && !do_push;
    end

    assign overflow = overflow_q;
    assign row_out  = row_out_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed plus randomized presses against a tick-level
// behavioural model of the keypad scanner and its output queue.
module tb_keypad_scanner;

    localparam int TD = 4;
    localparam int DB = 3;
`ifdef KEYPAD_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_ready = 1'b0;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        overflow;
    logic [15:0] pressed = 16'h0000;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    keypad_scanner #(.TICK_DIV(TD), .DEBOUNCE_TICKS(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .row_out   (row_out),
        .col_in    (col_in),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ready (key_ready),
        .overflow  (overflow)
    );

    // Physical keypad: a pressed key shorts its column to the row being driven low.
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase 0: hunting rows, 1: confirming a candidate, 2: waiting for release
    int  m_phase = 0;
    int  m_row = 0;
    int  m_col = 0;
    int  m_code = 0;
    int  m_streak = 0;
    int  m_tphase = 0;
    bit  m_emit = 0;
    bit  m_ovf = 0;
    bit  m_pop;
    bit  model_ok = 0;
    int  tick_edges = 0;
    int  m_q[$];
    logic [3:0] m_keys;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_phase = 0; m_row = 0; m_streak = 0; m_tphase = 0;
                m_emit = 0; m_ovf = 0; m_q.delete();
            end else begin
                m_pop = (m_q.size() > 0) && key_ready;
                if (m_pop) void'(m_q.pop_front());
                m_ovf = 0;
                if (m_emit) begin
                    if (m_q.size() < DEPTH) m_q.push_back(m_code);
                    else m_ovf = 1;
                    m_emit = 0;
                end
                if (m_tphase == TD - 1) begin
                    tick_edges++;
                    m_keys = pressed[m_row*4 +: 4];
                    if (m_phase == 0) begin
                        if (m_keys != 4'h0) begin
                            m_col = 0;
                            while (!m_keys[m_col]) m_col++;
                            m_code = m_row * 4 + m_col;
                            m_streak = 1;
                            m_phase = 1;
                        end else begin
                            m_row = (m_row + 1) % 4;
                        end
                    end else if (m_phase == 1) begin
                        if (m_keys[m_col]) m_streak++;
                        else begin
                            m_row = (m_row + 1) % 4;
                            m_phase = 0;
                        end
                    end else begin
                        if (m_keys == 4'h0) begin
                            m_streak++;
                            if (m_streak == DB) begin
                                m_row = (m_row + 1) % 4;
                                m_phase = 0;
                            end
                        end else m_streak = 0;
                    end
                    if (m_phase == 1 && m_streak >= DB) begin
                        m_emit = 1;
                        m_phase = 2;
                        m_streak = 0;
                    end
                end
                m_tphase = (m_tphase + 1) % TD;
            end
            model_ok = 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    int xfers[$];
    int ovf_pulses = 0;
    logic [3:0] exp_row_out;

    initial begin
        forever begin
            @(negedge clk);
            if (model_ok) begin
                exp_row_out = ~(4'b0001 << m_row);
                chk("row_out", row_out, exp_row_out);
                chk("key_valid", key_valid, (m_q.size() > 0) ? 1 : 0);
                if (m_q.size() > 0) chk("key_code", key_code, m_q[0]);
                chk("overflow", overflow, m_ovf);
                if (key_valid && key_ready) begin
                    xfers.push_back(key_code);
                    $display("[TB] transfer key_code=%0d at %0t", key_code, $time);
                end
                if (overflow) ovf_pulses++;
            end
        end
    end

    // Random consumer back-pressure during the random phase.
    bit rand_en = 0;
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_en) key_ready = ($urandom_range(0, 9) < 6);
        end
    end

    // Returns 1 time unit after the n-th following tick edge.
    task automatic wait_ticks(input int n);
        int target = tick_edges + n;
        int budget = n * TD + 4 * TD;
        while (tick_edges < target && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        if (tick_edges < target) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_ticks: timeout, got %0d ticks, expected %0d", tick_edges, target);
        end
    endtask

    task automatic press_release(input int code);
        pressed = 16'h0000;
        pressed[code] = 1'b1;
        wait_ticks(8);
        pressed = 16'h0000;
        wait_ticks(5);
    endtask

    logic [3:0] row_tab [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    int ov_codes [5] = '{5, 14, 0, 11, 7};
    int budget;
    logic [15:0] rnd_keys;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset for 3 cycles, check values while held.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_row_out", row_out, 4'b1110);
        chk("rst_key_valid", key_valid, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_key_code", key_code, 0);
        rst = 1'b0;

        // Idle row cycling.
        for (int i = 0; i < 4; i++) begin
            wait_ticks(1);
            chk("idle_row_cycle", row_out, row_tab[i]);
        end

        // Single press of key 9 (row 2, col 1), held 10 ticks.
        key_ready = 1'b1;
        xfers.delete();
        pressed[9] = 1'b1;
        wait_ticks(10);
        pressed = 16'h0000;
        wait_ticks(6);
        chk("single_xfer_count", xfers.size(), 1);
        if (xfers.size() > 0) chk("single_code", xfers[0], 9);

        // Bounce: col 1 low for only 2 ticks while row 2 is driven.
        xfers.delete();
        budget = 8;
        while (m_row != 2 && budget > 0) begin
            wait_ticks(1);
            budget--;
        end
        chk("bounce_on_row2", row_out, 4'b1011);
        pressed[9] = 1'b1;
        wait_ticks(2);
        pressed = 16'h0000;
        wait_ticks(1);
        chk("bounce_resume_row3", row_out, 4'b0111);
        chk("bounce_no_valid", key_valid, 0);
        wait_ticks(4);
        chk("bounce_no_xfer", xfers.size(), 0);

        // Overflow: consumer stalled, DEPTH+1 keys.
        key_ready = 1'b0;
        xfers.delete();
        ovf_pulses = 0;
        for (int i = 0; i < DEPTH + 1; i++) press_release(ov_codes[i]);
        chk("ovf_pulses", ovf_pulses, 1);
        chk("ovf_valid", key_valid, 1);
        chk("ovf_head_code", key_code, ov_codes[0]);
        key_ready = 1'b1;
        repeat (DEPTH + 2) @(posedge clk);
        #1;
        key_ready = 1'b0;
        chk("ovf_drain_count", xfers.size(), DEPTH);
        for (int i = 0; i < DEPTH; i++)
            if (i < xfers.size()) chk("ovf_order", xfers[i], ov_codes[i]);

        // Simultaneous push and pop with a full buffer.
        wait_ticks(1);
        xfers.delete();
        ovf_pulses = 0;
        for (int i = 0; i < DEPTH; i++) press_release(6);
        chk("sim_full_valid", key_valid, 1);
        pressed[13] = 1'b1;
        budget = 64;
        while (!m_emit && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        chk("sim_reached_emit", m_emit, 1);
        key_ready = 1'b1;
        @(posedge clk);
        #1;
        key_ready = 1'b0;
        chk("sim_no_overflow", overflow, 0);
        chk("sim_valid", key_valid, 1);
        chk("sim_head_code", key_code, (DEPTH == 1) ? 13 : 6);
        wait_ticks(1);
        pressed = 16'h0000;
        wait_ticks(5);
        key_ready = 1'b1;
        repeat (DEPTH + 2) @(posedge clk);
        #1;
        key_ready = 1'b0;
        chk("sim_xfer_count", xfers.size(), DEPTH + 1);
        if (xfers.size() > 0) chk("sim_last_code", xfers[xfers.size()-1], 13);
        chk("sim_ovf_pulses", ovf_pulses, 0);

        // Reset while debouncing discards the key.
        wait_ticks(1);
        xfers.delete();
        key_ready = 1'b1;
        pressed[4] = 1'b1;
        budget = 8;
        while (m_phase != 1 && budget > 0) begin
            wait_ticks(1);
            budget--;
        end
        chk("midrst_in_debounce", m_phase, 1);
        rst = 1'b1;
        pressed = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_row_out", row_out, 4'b1110);
        chk("midrst_valid", key_valid, 0);
        chk("midrst_overflow", overflow, 0);
        chk("midrst_code", key_code, 0);
        rst = 1'b0;
        wait_ticks(8);
        chk("midrst_no_xfer", xfers.size(), 0);

        // Randomized presses and back-pressure, checked every cycle by the model.
        rand_en = 1;
        for (int k = 0; k < 60; k++) begin
            wait_ticks($urandom_range(1, 7));
            case ($urandom_range(0, 3))
                0, 1: rnd_keys = 16'h0000;
                2: rnd_keys = 16'h0001 << $urandom_range(0, 15);
                default: rnd_keys = (16'h0001 << $urandom_range(0, 15)) |
                                    (16'h0001 << $urandom_range(0, 15));
            endcase
            pressed = rnd_keys;
        end
        pressed = 16'h0000;
        wait_ticks(6);
        rand_en = 0;
        key_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("final_drained", key_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
